// File: rtl/stack_op_sequencer.sv
// Multi-cycle command sequencer in front of the processor stack: turns PUSHI/POP/ALU/DUP
// commands into stack pop/push cycles. Optional MUL (op 110) is built when STACK_SEQ_MUL_EN is defined.
`timescale 1ns/1ps
module stack_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_imm,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [WIDTH-1:0]           stk_din,
    input  logic [WIDTH-1:0]           stk_dout,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_data,
    output logic                       err,
    output logic                       flag_c,
    output logic                       flag_z,
    output logic [$clog2(DEPTH):0]     depth
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_C   = DW'(1);
    localparam logic [DW-1:0] TWO_C   = DW'(2);

    localparam logic [2:0] OP_PUSHI = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_DUP   = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP1  = 3'd1,
        POP2  = 3'd2,
        CAPT  = 3'd3,
        PUSH  = 3'd4,
        PUSH2 = 3'd5,
        RESP  = 3'd6,
        ERR   = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic [WIDTH-1:0]  res_data_q, res_data_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_z_q, flag_z_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic              ready_q, ready_d;
    logic              res_valid_q, res_valid_d;
    logic              err_q, err_d;

    logic              legal_s;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH:0]    diff_s;
    logic [WIDTH-1:0]  alu_r_s;
    logic              alu_c_s;
    logic              alu_z_upd_s;
`ifdef STACK_SEQ_MUL_EN
    logic [WIDTH-1:0]  prod_s;
`endif

    // Depth requirement of the command presented in IDLE
    always_comb begin
        legal_s = 1'b0;
        case (cmd_op)
            OP_PUSHI: legal_s = (depth_q < DEPTH_C);
            OP_POP:   legal_s = (depth_q >= ONE_C);
            OP_NOT:   legal_s = (depth_q >= ONE_C);
            OP_ADD:   legal_s = (depth_q >= TWO_C);
            OP_SUB:   legal_s = (depth_q >= TWO_C);
            OP_AND:   legal_s = (depth_q >= TWO_C);
`ifdef STACK_SEQ_MUL_EN
            OP_MUL:   legal_s = (depth_q >= TWO_C);
`else
            OP_MUL:   legal_s = 1'b0;
`endif
            OP_DUP:   legal_s = (depth_q >= ONE_C) && (depth_q < DEPTH_C);
            default:  legal_s = 1'b0;
        endcase
    end

    // ALU: A is the word arriving on stk_dout in CAPT, B was captured in POP2
    always_comb begin
        sum_s       = {1'b0, stk_dout} + {1'b0, b_q};
        diff_s      = {1'b0, stk_dout} - {1'b0, b_q};
`ifdef STACK_SEQ_MUL_EN
        prod_s      = stk_dout * b_q;
`endif
        alu_r_s     = stk_dout;
        alu_c_s     = flag_c_q;
        alu_z_upd_s = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_r_s = sum_s[WIDTH-1:0];
                alu_c_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                alu_r_s = diff_s[WIDTH-1:0];
                alu_c_s = diff_s[WIDTH];
            end
            OP_AND: alu_r_s = stk_dout & b_q;
            OP_NOT: alu_r_s = ~stk_dout;
`ifdef STACK_SEQ_MUL_EN
            OP_MUL: alu_r_s = prod_s;
`endif
            default: alu_z_upd_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic; outputs are registered images of the next state
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        b_d        = b_q;
        din_d      = din_q;
        res_data_d = res_data_q;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    if (!legal_s) begin
                        state_d = ERR;
                    end else if (cmd_op == OP_PUSHI) begin
                        state_d = PUSH;
                        din_d   = cmd_imm;
                    end else begin
                        state_d = POP1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            POP1: begin
                if ((op_q == OP_POP) || (op_q == OP_NOT) || (op_q == OP_DUP)) begin
                    state_d = CAPT;
                end else begin
                    state_d = POP2;
                end
            end
            POP2: begin
                b_d     = stk_dout;
                state_d = CAPT;
            end
            CAPT: begin
                if (op_q == OP_POP) begin
                    res_data_d = stk_dout;
                    state_d    = RESP;
                end else if (op_q == OP_DUP) begin
                    din_d   = stk_dout;
                    state_d = PUSH;
                end else begin
                    din_d    = alu_r_s;
                    flag_c_d = alu_c_s;
                    flag_z_d = alu_z_upd_s ? (alu_r_s == '0) : flag_z_q;
                    state_d  = PUSH;
                end
            end
            PUSH: begin
                if (op_q == OP_DUP) begin
                    state_d = PUSH2;
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH2:   state_d = IDLE;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        push_d      = (state_d == PUSH) || (state_d == PUSH2);
        pop_d       = (state_d == POP1) || (state_d == POP2);
        ready_d     = (state_d == IDLE);
        res_valid_d = (state_d == RESP);
        err_d       = (state_d == ERR);

        // depth follows the stack strobes actually presented this cycle
        if (push_q) begin
            depth_d = depth_q + ONE_C;
        end else if (pop_q) begin
            depth_d = depth_q - ONE_C;
        end else begin
            depth_d = depth_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= 3'b000;
            b_q         <= '0;
            din_q       <= '0;
            res_data_q  <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            depth_q     <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            b_q         <= b_d;
            din_q       <= din_d;
            res_data_q  <= res_data_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            depth_q     <= depth_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_din   = din_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign depth     = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a behavioural stack (registered Dout) attached.
`timescale 1ns/1ps
module tb_stack_op_sequencer;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int DW = 5;

    localparam logic [2:0] PUSHI = 3'b000;
    localparam logic [2:0] POP   = 3'b001;
    localparam logic [2:0] ADD   = 3'b010;
    localparam logic [2:0] SUB   = 3'b011;
    localparam logic [2:0] AND_OP = 3'b100;
    localparam logic [2:0] NOT_OP = 3'b101;
    localparam logic [2:0] MUL   = 3'b110;
    localparam logic [2:0] DUP   = 3'b111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'b000;
    logic [W-1:0]  cmd_imm = '0;
    logic          stk_push, stk_pop;
    logic [W-1:0]  stk_din;
    logic [W-1:0]  stk_dout;
    logic          res_valid;
    logic [W-1:0]  res_data;
    logic          err, flag_c, flag_z;
    logic [DW-1:0] depth;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
        .res_valid(res_valid), .res_data(res_data), .err(err),
        .flag_c(flag_c), .flag_z(flag_z), .depth(depth)
    );

    // Behavioural stack: Dout registered, valid the cycle after pop
    logic [W-1:0] mem [0:31];
    int sp;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp       <= 0;
            stk_dout <= '0;
        end else if (stk_push) begin
            mem[sp & 31] <= stk_din;
            sp           <= sp + 1;
        end else if (stk_pop) begin
            stk_dout <= mem[(sp - 1) & 31];
            sp       <= sp - 1;
        end
    end

    // Event counters sampled mid-cycle
    int res_cnt = 0, err_cnt = 0, pop_cnt = 0, both_cnt = 0;
    logic [W-1:0] last_din = '0;
    always @(negedge clk) begin
        if (res_valid) res_cnt++;
        if (err) err_cnt++;
        if (stk_pop) pop_cnt++;
        if (stk_push && stk_pop) both_cnt++;
        if (stk_push) last_din = stk_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and return the number of cycles from accept to ready
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] imm, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b111;
        cmd_imm   = 8'hAA;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cmd_ready && lat < 50);
        if (!cmd_ready) check("busy_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int lat, base_res, base_err, base_pop;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_push_pop", {30'd0, stk_push, stk_pop}, 32'd0);
        check("rst_depth", {27'd0, depth}, 32'd0);
        check("rst_outs", {12'd0, res_data, stk_din, res_valid, err, flag_c, flag_z}, 32'd0);
        rst = 1'b1;

        // 5 - 3 = 2
        do_cmd(PUSHI, 8'h05, lat);
        check("pushi_latency", lat, 32'd2);
        do_cmd(PUSHI, 8'h03, lat);
        do_cmd(SUB, 8'h00, lat);
        check("sub_latency", lat, 32'd5);
        check("sub_din", {24'd0, last_din}, 32'h02);
        check("sub_depth", {27'd0, depth}, 32'd1);
        check("sub_flags", {30'd0, flag_c, flag_z}, 32'd0);
        do_cmd(POP, 8'h00, lat);
        check("pop_02", {24'd0, res_data}, 32'h02);

        // 3 - 5 borrows
        base_res = res_cnt;
        do_cmd(PUSHI, 8'h03, lat);
        do_cmd(PUSHI, 8'h05, lat);
        do_cmd(SUB, 8'h00, lat);
        do_cmd(POP, 8'h00, lat);
        check("sub_borrow_res", {24'd0, res_data}, 32'hFE);
        check("sub_borrow_pulses", res_cnt - base_res, 32'd1);
        check("sub_borrow_c", {31'd0, flag_c}, 32'd1);
        check("sub_borrow_depth", {27'd0, depth}, 32'd0);

        // 0xFF + 0x01 carries to zero
        do_cmd(PUSHI, 8'hFF, lat);
        do_cmd(PUSHI, 8'h01, lat);
        do_cmd(ADD, 8'h00, lat);
        do_cmd(POP, 8'h00, lat);
        check("add_res", {24'd0, res_data}, 32'h00);
        check("add_cz", {30'd0, flag_c, flag_z}, 32'd3);

        // Underflow rejections
        base_err = err_cnt;
        base_pop = pop_cnt;
        do_cmd(POP, 8'h00, lat);
        check("err_latency", lat, 32'd2);
        check("pop_empty_err", err_cnt - base_err, 32'd1);
        do_cmd(PUSHI, 8'h09, lat);
        do_cmd(ADD, 8'h00, lat);
        check("add_d1_err", err_cnt - base_err, 32'd2);
        check("underflow_no_pop", pop_cnt - base_pop, 32'd0);
        check("underflow_depth", {27'd0, depth}, 32'd1);

        // AND then NOT: ~(0x09 & 0x0C) = 0xF7, carry untouched
        do_cmd(PUSHI, 8'h0C, lat);
        do_cmd(AND_OP, 8'h00, lat);
        check("and_din", {24'd0, last_din}, 32'h08);
        do_cmd(NOT_OP, 8'h00, lat);
        do_cmd(POP, 8'h00, lat);
        check("not_res", {24'd0, res_data}, 32'hF7);
        check("not_cz", {30'd0, flag_c, flag_z}, 32'd2);

        // Fill to capacity, then overflow rejections
        for (int i = 0; i < 16; i++) do_cmd(PUSHI, 8'(8'h10 + i), lat);
        check("full_depth", {27'd0, depth}, 32'd16);
        base_err = err_cnt;
        do_cmd(PUSHI, 8'h55, lat);
        do_cmd(DUP, 8'h00, lat);
        check("overflow_errs", err_cnt - base_err, 32'd2);
        check("overflow_depth", {27'd0, depth}, 32'd16);
        do_cmd(POP, 8'h00, lat);
        check("full_pop", {24'd0, res_data}, 32'h1F);
        for (int i = 0; i < 15; i++) do_cmd(POP, 8'h00, lat);
        check("drain_last", {24'd0, res_data}, 32'h10);
        check("drain_depth", {27'd0, depth}, 32'd0);

        // DUP then MUL
        base_err = err_cnt;
        do_cmd(PUSHI, 8'h07, lat);
        do_cmd(DUP, 8'h00, lat);
        check("dup_depth", {27'd0, depth}, 32'd2);
        do_cmd(MUL, 8'h00, lat);
        do_cmd(POP, 8'h00, lat);
`ifdef STACK_SEQ_MUL_EN
        check("mul_res", {24'd0, res_data}, 32'h31);
        check("mul_no_err", err_cnt - base_err, 32'd0);
        check("mul_depth", {27'd0, depth}, 32'd0);
`else
        check("mul_off_res", {24'd0, res_data}, 32'h07);
        check("mul_off_err", err_cnt - base_err, 32'd1);
        check("mul_off_depth", {27'd0, depth}, 32'd1);
        do_cmd(POP, 8'h00, lat);
        check("dup_second", {24'd0, res_data}, 32'h07);
`endif

        // Reset in the middle of an ADD
        do_cmd(PUSHI, 8'h01, lat);
        do_cmd(PUSHI, 8'h02, lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("midadd_pop", {31'd0, stk_pop}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        check("midrst_depth", {27'd0, depth}, 32'd0);
        check("midrst_outs", {12'd0, res_data, stk_din, res_valid, err, flag_c, flag_z}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_cmd(PUSHI, 8'h42, lat);
        do_cmd(POP, 8'h00, lat);
        check("post_rst_pop", {24'd0, res_data}, 32'h42);
        check("never_both", both_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Multi-cycle operation sequencer that sits directly upstream of the 8-bit processor stack; it is the only block that drives that stack's push/pop/Din and reads its Dout.
- Accepts one stack command at a time from the controller (push immediate, pop, ALU op, dup).
- Issues the required pop/push cycles to the stack, tracks depth, and flags underflow and overflow.
- Returns popped values and ADD/SUB flags to the controller.

Parameters:
- WIDTH, 8, data width; matches the stack word.
- DEPTH, 16, stack capacity in entries; depth counter is clog2(DEPTH)+1 bits.

Ports:
- clk  in  1  rising-edge clock, shared with the stack.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle and able to accept.
- cmd_op  in  3  000 PUSHI, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 MUL (optional), 111 DUP.
- cmd_imm  in  WIDTH  immediate for PUSHI.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_din  out  WIDTH  to stack Din.
- stk_dout  in  WIDTH  from stack Dout; registered, valid the cycle after stk_pop.
- res_valid  out  1  one-cycle pulse; res_data holds the POP result.
- res_data  out  WIDTH  popped value, held until the next POP.
- err  out  1  one-cycle pulse; command rejected.
- flag_c  out  1  ADD carry-out / SUB borrow; held between ADD/SUB.
- flag_z  out  1  last ADD/SUB/AND/NOT/MUL result was zero.
- depth  out  clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; cmd_ready=1; stk_push=stk_pop=0; stk_din=0; res_valid=0; res_data=0; err=0; flag_c=flag_z=0; depth=0. The integration resets the stack from the same source so that the stack pointer also returns to 0. Reset mid-operation abandons the command.
- FSM states: IDLE, POP1, POP2, CAPT, PUSH, PUSH2, RESP, ERR.
- stk_push and stk_pop are never asserted in the same cycle. Both are Moore outputs of the state.
- IDLE: cmd_ready=1. A handshake occurs when cmd_valid=1 in IDLE. The legality check is done in the same cycle:
  - Needs: PUSHI needs depth<DEPTH. POP and NOT need depth>=1. ADD, SUB, AND and MUL need depth>=2. DUP needs 1<=depth<DEPTH.
  - Illegal: go to ERR. err=1 for one cycle, then IDLE. No stack activity; depth and flags unchanged.
- Legal transitions:
  - PUSHI: PUSH (stk_din=cmd_imm) -> IDLE. Latency 2 cycles, accept to ready.
  - POP: POP1 -> CAPT (capture stk_dout into res_data) -> RESP (res_valid=1) -> IDLE.
  - Binary ops: POP1 -> POP2 (capture B=stk_dout, stk_pop=1) -> CAPT (capture A=stk_dout, compute) -> PUSH (stk_din=result) -> IDLE. B is the former top of stack.
  - NOT: POP1 -> CAPT -> PUSH(~A) -> IDLE.
  - DUP: POP1 -> CAPT -> PUSH(A) -> PUSH2(A) -> IDLE.
- Arithmetic: computed on WIDTH+1 bits.
  - ADD: {flag_c,r} = A+B.
  - SUB: r = A-B mod 2^WIDTH; flag_c=1 iff A<B (unsigned).
  - AND: r = A&B.
  - flag_z = (r==0) for ADD/SUB/AND/NOT/MUL. flag_c is unchanged by non-ADD/SUB ops.
- Depth: decrements in every stk_pop cycle and increments in every stk_push cycle. It never wraps, because of the IDLE checks.
- cmd_op and cmd_imm are sampled only at the handshake. Changes while busy are ignored.

Optional Feature:
- Macro: STACK_SEQ_MUL_EN.
- Defined: op 110 = MUL, with the binary-op sequence and r = low WIDTH bits of A*B. flag_z is updated; flag_c is unchanged.
- Undefined: op 110 is always illegal (ERR path, err pulse, no stack activity). No multiplier is synthesized.

Test Plan:
- Reset then PUSHI 0x05, PUSHI 0x03, SUB -> stack push sees Din 0x02; depth=1; flag_c=0; flag_z=0. SUB accept-to-ready takes 5 cycles.
- PUSHI 0x03, PUSHI 0x05, SUB, POP -> res_data=0xFE with a single res_valid pulse; flag_c=1; depth=0.
- PUSHI 0xFF, PUSHI 0x01, ADD, POP -> res_data=0x00; flag_c=1; flag_z=1.
- Empty stack: POP, then ADD with depth=1 -> err pulses once per command; stk_pop never asserted; depth unchanged.
- 16x PUSHI then PUSHI and DUP -> err pulses; depth stays 16. Then POP -> res_data equals the 16th immediate.
- PUSHI 0x07, DUP, MUL, POP -> with STACK_SEQ_MUL_EN: res_data=0x31. Without it: MUL errs, and POP returns 0x07. Reset asserted mid-ADD -> all outputs 0 and depth=0 immediately.
